// File: rtl/cmd_timeout_guard_if.sv
// cmd_intf: one-cycle sel/ack command bus between the FMC bridge and its targets.
// mst drives the request; slv answers with rdata/ack.
interface cmd_intf #(
  parameter int ADDR_BITS = 24,
  parameter int DATA_BITS = 32
);
  logic                 sel;
  logic                 rd_wr_n;
  logic [ADDR_BITS-1:0] byte_addr;
  logic [DATA_BITS-1:0] wdata;
  logic [DATA_BITS-1:0] rdata;
  logic                 ack;

  modport mst (
    output sel, rd_wr_n, byte_addr, wdata,
    input  rdata, ack
  );

  modport slv (
    input  sel, rd_wr_n, byte_addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/cmd_timeout_guard.sv
// cmd_timeout_guard: forwards cmd_intf requests and guarantees an upstream ack,
// synthesizing an error ack when the target stays silent too long.
module cmd_timeout_guard #(
  parameter int                   ADDR_BITS      = 24,
  parameter int                   DATA_BITS      = 32,
  parameter int                   TIMEOUT_CYCLES = 256,
  parameter logic [DATA_BITS-1:0] ERR_RDATA      = 32'hDEAD_BEEF,
  parameter int                   CNT_BITS       = 16
) (
  input  logic                i_sys_clk,
  input  logic                i_sys_rst_n,
  cmd_intf.slv                i_cmd,
  cmd_intf.mst                o_cmd,
  input  logic                i_clr_count,
  output logic [CNT_BITS-1:0] o_timeout_count,
  output logic                o_timeout,
  output logic                o_stray_ack,
  output logic                o_proto_err
);

  localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] LAST = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [WW-1:0]        wcnt_q, wcnt_d;
  logic                 osel_q, osel_d;
  logic                 rw_q, rw_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 ack_q, ack_d;
  logic                 tmo_q, tmo_d;
  logic                 stray_q, stray_d;
  logic                 proto_q, proto_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      osel_q  <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      tmo_q   <= 1'b0;
      stray_q <= 1'b0;
      proto_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      osel_q  <= osel_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      tmo_q   <= tmo_d;
      stray_q <= stray_d;
      proto_q <= proto_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    osel_d  = 1'b0;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    tmo_d   = 1'b0;
    stray_d = 1'b0;
    proto_d = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        stray_d = o_cmd.ack;
        if (i_cmd.sel) begin
          rw_d    = i_cmd.rd_wr_n;
          addr_d  = i_cmd.byte_addr;
          wdata_d = i_cmd.wdata;
          osel_d  = 1'b1;
          wcnt_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        proto_d = i_cmd.sel;
        if (o_cmd.ack) begin
          ack_d   = 1'b1;
          rdata_d = o_cmd.rdata;
          state_d = IDLE;
        end else if (wcnt_q == LAST) begin
          ack_d   = 1'b1;
          rdata_d = ERR_RDATA;
          tmo_d   = 1'b1;
          state_d = IDLE;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // clear beats a coincident increment
    if (i_clr_count) cnt_d = '0;
  end

  assign o_cmd.sel       = osel_q;
  assign o_cmd.rd_wr_n   = rw_q;
  assign o_cmd.byte_addr = addr_q;
  assign o_cmd.wdata     = wdata_q;
  assign i_cmd.rdata     = rdata_q;
  assign i_cmd.ack       = ack_q;
  assign o_timeout_count = cnt_q;
  assign o_timeout       = tmo_q;
  assign o_stray_ack     = stray_q;
  assign o_proto_err     = proto_q;

endmodule

// File: tb/tb_cmd_timeout_guard.sv
// Directed bench for cmd_timeout_guard with TIMEOUT_CYCLES=8 and CNT_BITS=2.
module tb_cmd_timeout_guard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] cnt;
  logic       tmo, stray, proto;
  int         n_chk = 0;
  int         n_fail = 0;

  cmd_intf #(.ADDR_BITS(24), .DATA_BITS(32)) up ();
  cmd_intf #(.ADDR_BITS(24), .DATA_BITS(32)) dn ();

  cmd_timeout_guard #(
    .ADDR_BITS(24), .DATA_BITS(32), .TIMEOUT_CYCLES(8),
    .ERR_RDATA(32'hDEAD_BEEF), .CNT_BITS(2)
  ) dut (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n),
    .i_cmd(up), .o_cmd(dn),
    .i_clr_count(clr), .o_timeout_count(cnt),
    .o_timeout(tmo), .o_stray_ack(stray), .o_proto_err(proto)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic rw, input logic [23:0] a,
                     input logic [31:0] w);
    up.sel = 1'b1;
    up.rd_wr_n = rw;
    up.byte_addr = a;
    up.wdata = w;
    tick();
    up.sel = 1'b0;
  endtask

  task automatic run_timeout(input string tag);
    req(1'b1, 24'h000100, 32'h0);
    repeat (8) tick();
    chk({tag, "_ack"}, 32'(up.ack), 32'd1);
    chk({tag, "_tmo"}, 32'(tmo), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    up.sel = 1'b0; up.rd_wr_n = 1'b0;
    up.byte_addr = '0; up.wdata = '0;
    dn.ack = 1'b0; dn.rdata = '0;
    #22;
    chk("rst_osel", 32'(dn.sel), 32'd0);
    chk("rst_ack", 32'(up.ack), 32'd0);
    chk("rst_rdata", up.rdata, 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: read, target acks at wait cycle 2
    req(1'b1, 24'h000010, 32'h0);
    chk("t1_osel", 32'(dn.sel), 32'd1);
    chk("t1_addr", 32'(dn.byte_addr), 32'h10);
    chk("t1_rw", 32'(dn.rd_wr_n), 32'd1);
    tick();
    chk("t1_osel_pulse", 32'(dn.sel), 32'd0);
    tick();
    dn.ack = 1'b1; dn.rdata = 32'h12345678;
    chk("t1_noack", 32'(up.ack), 32'd0);
    tick();
    dn.ack = 1'b0; dn.rdata = 32'h0;
    chk("t1_ack", 32'(up.ack), 32'd1);
    chk("t1_rdata", up.rdata, 32'h12345678);
    tick();
    chk("t1_ack_pulse", 32'(up.ack), 32'd0);
    chk("t1_rdata_hold", up.rdata, 32'h12345678);
    chk("t1_cnt", 32'(cnt), 32'd0);

    // 2: timeout, then late ack 3 cycles later
    req(1'b0, 24'h000020, 32'hCAFE0001);
    chk("t2_wdata", dn.wdata, 32'hCAFE0001);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("t2_wait_noack", 32'(up.ack), 32'd0);
    end
    tick();
    chk("t2_ack", 32'(up.ack), 32'd1);
    chk("t2_tmo", 32'(tmo), 32'd1);
    chk("t2_rdata", up.rdata, 32'hDEADBEEF);
    chk("t2_cnt", 32'(cnt), 32'd1);
    tick(); tick(); tick();
    dn.ack = 1'b1;
    tick();
    dn.ack = 1'b0;
    chk("t2_stray", 32'(stray), 32'd1);
    chk("t2_late_noack", 32'(up.ack), 32'd0);

    // 3: boundary acks at wait cycles 7 and 8
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t3_clr", 32'(cnt), 32'd0);
    req(1'b1, 24'h000030, 32'h0);
    repeat (7) tick();
    dn.ack = 1'b1; dn.rdata = 32'hA5A50007;
    tick();
    dn.ack = 1'b0;
    chk("t3_c7_ack", 32'(up.ack), 32'd1);
    chk("t3_c7_rdata", up.rdata, 32'hA5A50007);
    chk("t3_c7_tmo", 32'(tmo), 32'd0);
    chk("t3_c7_cnt", 32'(cnt), 32'd0);
    tick();
    req(1'b1, 24'h000031, 32'h0);
    repeat (8) tick();
    chk("t3_c8_tmo", 32'(tmo), 32'd1);
    dn.ack = 1'b1; dn.rdata = 32'h11111111;
    tick();
    dn.ack = 1'b0;
    chk("t3_c8_stray", 32'(stray), 32'd1);
    chk("t3_c8_noack", 32'(up.ack), 32'd0);
    chk("t3_c8_rdata", up.rdata, 32'hDEADBEEF);

    // 4: extra sel while waiting
    req(1'b1, 24'h000040, 32'h0);
    tick();
    up.sel = 1'b1; up.byte_addr = 24'h000099;
    tick();
    up.sel = 1'b0;
    chk("t4_proto", 32'(proto), 32'd1);
    chk("t4_no_fwd", 32'(dn.sel), 32'd0);
    chk("t4_addr_kept", 32'(dn.byte_addr), 32'h40);
    dn.ack = 1'b1; dn.rdata = 32'h44444444;
    tick();
    dn.ack = 1'b0;
    chk("t4_ack", 32'(up.ack), 32'd1);
    chk("t4_proto_pulse", 32'(proto), 32'd0);
    tick();
    chk("t4_one_ack", 32'(up.ack), 32'd0);
    chk("t4_one_sel", 32'(dn.sel), 32'd0);

    // 5: saturation then clear-with-increment
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 5; i++) run_timeout("t5_to");
    chk("t5_sat", 32'(cnt), 32'd3);
    req(1'b1, 24'h000050, 32'h0);
    repeat (7) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_tmo6", 32'(tmo), 32'd1);
    chk("t5_clr_wins", 32'(cnt), 32'd0);

    // 6: reset during WAIT, stray after release, then normal op
    req(1'b1, 24'h000060, 32'h0);
    chk("t6_osel", 32'(dn.sel), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_osel", 32'(dn.sel), 32'd0);
    chk("t6_rst_addr", 32'(dn.byte_addr), 32'd0);
    chk("t6_rst_rdata", up.rdata, 32'd0);
    tick(); tick();
    #3;
    rst_n = 1'b1;
    tick();
    dn.ack = 1'b1;
    tick();
    dn.ack = 1'b0;
    chk("t6_stray", 32'(stray), 32'd1);
    chk("t6_noack", 32'(up.ack), 32'd0);
    req(1'b0, 24'h000061, 32'h66);
    dn.ack = 1'b1; dn.rdata = 32'h66660000;
    tick();
    dn.ack = 1'b0;
    chk("t6_ack", 32'(up.ack), 32'd1);
    chk("t6_rdata", up.rdata, 32'h66660000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
